// File: rtl/bp_nonsynth_stall_histogram.sv
// Stall-reason histogram. Each cycle, one profiler classification (a stall code or an
// instret flag) bumps one live bin. A snapshot FSM copies the live bins into a shadow
// bank, one bin per cycle. Host software reads the shadow bank through a
// valid/yumi read port.
// Optional build macro: BP_STALL_HIST_SATURATE_EN. When it is defined, bins saturate at
// all-ones and keep a sticky per-bin overflow bit. When it is undefined, bins wrap.
module bp_nonsynth_stall_histogram #(
    parameter int cnt_width_p = 32,
    parameter int num_bins_p  = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       freeze_i,
    input  logic                       v_i,
    input  logic                       instret_i,
    input  logic [4:0]                 reason_i,
    input  logic                       clear_i,
    input  logic                       snapshot_i,
    output logic                       snapshot_busy_o,
    input  logic                       rd_v_i,
    input  logic [4:0]                 rd_addr_i,
    output logic                       rd_ready_o,
    output logic                       rd_v_o,
    output logic [cnt_width_p-1:0]     rd_data_o,
    input  logic                       rd_yumi_i
);

    localparam int lg_num_bins_lp = $clog2(num_bins_p);
    localparam logic [lg_num_bins_lp-1:0] last_bin_lp = lg_num_bins_lp'(num_bins_p - 1);
    localparam logic [cnt_width_p-1:0]    one_lp      = cnt_width_p'(1);

    localparam logic [1:0] e_idle = 2'd0;
    localparam logic [1:0] e_copy = 2'd1;
    localparam logic [1:0] e_done = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [lg_num_bins_lp-1:0] idx_q, idx_d;
    logic                      rd_v_q, rd_v_d;
    logic [cnt_width_p-1:0]    rd_data_q, rd_data_d;

    logic [cnt_width_p-1:0]    live_w      [num_bins_p];
    logic [cnt_width_p-1:0]    live_next_w [num_bins_p];
    logic [cnt_width_p-1:0]    shadow_q    [num_bins_p];

    // Bin 31 is reserved for retired instructions. Code 31 on a stall is illegal and is
    // folded into bin 0, the "unknown" bin.
    logic [lg_num_bins_lp-1:0] bin_sel;
    logic                      inc_en;
    logic                      busy;
    logic                      rd_accept;

    assign bin_sel = instret_i ? last_bin_lp
                   : ((reason_i == last_bin_lp) ? '0 : reason_i);
    // Clear takes priority: an increment that arrives in the same cycle as clear is dropped.
    assign inc_en  = v_i & ~freeze_i & ~clear_i;

    genvar gi;
    generate
        for (gi = 0; gi < num_bins_p; gi++) begin : g_bin
            logic [cnt_width_p-1:0] cnt_q, cnt_d;
            logic                   hit;

            assign hit            = inc_en & (bin_sel == lg_num_bins_lp'(gi));
            assign live_w[gi]      = cnt_q;
            assign live_next_w[gi] = cnt_d;

`ifdef BP_STALL_HIST_SATURATE_EN
            logic ovf_q;
            logic at_max;
            assign at_max = &cnt_q;

            // Next count: clear, saturating increment, or hold.
            always_comb begin
                cnt_d = cnt_q;
                if (clear_i)
                    cnt_d = '0;
                else if (hit && !at_max)
                    cnt_d = cnt_q + one_lp;
            end

            // Sticky overflow flag: set by an increment attempted at all-ones.
            always_ff @(posedge clk_i) begin
                if (reset_i)
                    ovf_q <= 1'b0;
                else if (hit && at_max)
                    ovf_q <= 1'b1;
            end

            if (gi == num_bins_p - 1) begin : g_ovf_report
`ifndef SYNTHESIS
                final begin
                    assert (!ovf_q) else $error("instret histogram bin saturated");
                end
`endif
            end
`else
            // Next count: clear, wrapping increment, or hold.
            always_comb begin
                cnt_d = cnt_q;
                if (clear_i)
                    cnt_d = '0;
                else if (hit)
                    cnt_d = cnt_q + one_lp;
            end
`endif

            // Live bin register.
            always_ff @(posedge clk_i) begin
                if (reset_i)
                    cnt_q <= '0;
                else
                    cnt_q <= cnt_d;
            end
        end
    endgenerate

    // Snapshot sequencing: idle -> copy (one bin per cycle) -> done -> idle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            e_idle: begin
                if (snapshot_i) begin
                    state_d = e_copy;
                    idx_d   = '0;
                end
            end
            e_copy: begin
                idx_d = idx_q + lg_num_bins_lp'(1);
                if (idx_q == last_bin_lp)
                    state_d = e_done;
            end
            e_done:  state_d = e_idle;
            default: state_d = e_idle;
        endcase
    end

    // FSM state and copy index registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // The shadow bank takes the post-update live value. This means a same-cycle increment
    // is included in the copy, and a same-cycle clear copies as zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_bins_p; i++)
                shadow_q[i] <= '0;
        end else if (state_q == e_copy) begin
            shadow_q[idx_q] <= live_next_w[idx_q];
        end
    end

    assign busy       = (state_q != e_idle);
    assign rd_ready_o = ~busy & (~rd_v_q | rd_yumi_i);
    assign rd_accept  = rd_v_i & rd_ready_o;

    // Read response: load on accept, hold until yumi, then drop valid.
    always_comb begin
        rd_v_d    = rd_v_q;
        rd_data_d = rd_data_q;
        if (rd_accept) begin
            rd_v_d    = 1'b1;
            rd_data_d = shadow_q[rd_addr_i];
        end else if (rd_yumi_i) begin
            rd_v_d = 1'b0;
        end
    end

    // Read response registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_v_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_v_q    <= rd_v_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign snapshot_busy_o = busy;
    assign rd_v_o          = rd_v_q;
    assign rd_data_o       = rd_data_q;

`ifndef SYNTHESIS
    // Stall code 31 is not a legal reason. Flag it when it is presented without instret.
    always_ff @(posedge clk_i) begin
        if (!reset_i && v_i && !instret_i)
            assert (reason_i != last_bin_lp) else $error("illegal stall reason code");
    end
`endif

endmodule

// File: tb/tb_bp_nonsynth_stall_histogram.sv
// Directed, table-driven bench for bp_nonsynth_stall_histogram. It uses a 32-bit instance
// for the main checks and a 4-bit instance for the wrap/saturate boundary.
`timescale 1ns/1ps
module tb_bp_nonsynth_stall_histogram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic        reset, freeze, v, instret, clear, snapshot, rd_v, rd_yumi;
    logic [4:0]  reason, rd_addr;
    logic        busy, rd_ready, rd_v_o;
    logic [31:0] rd_data;

    // Small (4-bit) instance signals
    logic        s_reset, s_freeze, s_v, s_instret, s_clear, s_snapshot, s_rd_v, s_rd_yumi;
    logic [4:0]  s_reason, s_rd_addr;
    logic        s_busy, s_rd_ready, s_rd_v_o;
    logic [3:0]  s_rd_data;

    bp_nonsynth_stall_histogram #(.cnt_width_p(32), .num_bins_p(32)) dut (
        .clk_i(clk), .reset_i(reset), .freeze_i(freeze), .v_i(v), .instret_i(instret),
        .reason_i(reason), .clear_i(clear), .snapshot_i(snapshot),
        .snapshot_busy_o(busy), .rd_v_i(rd_v), .rd_addr_i(rd_addr),
        .rd_ready_o(rd_ready), .rd_v_o(rd_v_o), .rd_data_o(rd_data), .rd_yumi_i(rd_yumi)
    );

    bp_nonsynth_stall_histogram #(.cnt_width_p(4), .num_bins_p(32)) dut_small (
        .clk_i(clk), .reset_i(s_reset), .freeze_i(s_freeze), .v_i(s_v), .instret_i(s_instret),
        .reason_i(s_reason), .clear_i(s_clear), .snapshot_i(s_snapshot),
        .snapshot_busy_o(s_busy), .rd_v_i(s_rd_v), .rd_addr_i(s_rd_addr),
        .rd_ready_o(s_rd_ready), .rd_v_o(s_rd_v_o), .rd_data_o(s_rd_data), .rd_yumi_i(s_rd_yumi)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       vv;
        logic       ins;
        logic       frz;
        logic [4:0] rsn;
        int         n;
        logic [4:0] addr;
        int         exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            step();
            k++;
        end
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: busy still 1 after 100 cycles, expected 0");
        end
    endtask

    task automatic do_snapshot();
        snapshot = 1'b1;
        step();
        snapshot = 1'b0;
        wait_idle();
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic read_bin(input logic [4:0] addr, input int exp, input string name);
        int k = 0;
        while (!rd_ready && k < 100) begin
            step();
            k++;
        end
        rd_v    = 1'b1;
        rd_addr = addr;
        step();
        rd_v    = 1'b0;
        check({name, " rd_v_o"}, rd_v_o, 1);
        check(name, rd_data, exp);
        $display("read bin %0d -> %0d (expect %0d)", addr, rd_data, exp);
        rd_yumi = 1'b1;
        step();
        rd_yumi = 1'b0;
    endtask

    task automatic run(input logic vv, input logic ins, input logic frz,
                       input logic [4:0] rsn, input int n);
        v       = vv;
        instret = ins;
        freeze  = frz;
        reason  = rsn;
        repeat (n) step();
        v       = 1'b0;
        instret = 1'b0;
        freeze  = 1'b0;
        reason  = '0;
    endtask

    task automatic s_snap_read(input int exp, input string name);
        int k = 0;
        s_snapshot = 1'b1;
        step();
        s_snapshot = 1'b0;
        while (s_busy && k < 100) begin
            step();
            k++;
        end
        check({name, " busy"}, s_busy, 0);
        s_rd_v    = 1'b1;
        s_rd_addr = 5'd0;
        step();
        s_rd_v    = 1'b0;
        check({name, " rd_v_o"}, s_rd_v_o, 1);
        check(name, s_rd_data, exp);
        $display("small read bin 0 -> %0d (expect %0d)", s_rd_data, exp);
        s_rd_yumi = 1'b1;
        step();
        s_rd_yumi = 1'b0;
    endtask

    initial begin
        int s_exp;
        // {v, instret, freeze, reason, cycles, read addr, expected}
        vecs[0] = '{1'b1, 1'b0, 1'b0, 5'd3,  20, 5'd3,  20};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 5'd3,   7, 5'd31,  7};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 5'd3,   7, 5'd3,   0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 5'd5,   9, 5'd5,   0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 5'd9,   6, 5'd9,   0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 5'd30, 12, 5'd30, 12};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 5'd0,   4, 5'd0,   4};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 5'd17,  1, 5'd17,  1};

        {reset, freeze, v, instret, clear, snapshot, rd_v, rd_yumi} = '0;
        reason = '0;
        rd_addr = '0;
        {s_freeze, s_v, s_instret, s_clear, s_snapshot, s_rd_v, s_rd_yumi} = '0;
        s_reason = '0;
        s_rd_addr = '0;
        reset = 1'b1;
        s_reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        s_reset = 1'b0;

        // Reset state
        check("reset busy", busy, 0);
        check("reset rd_v_o", rd_v_o, 0);
        check("reset rd_data", rd_data, 0);
        check("reset rd_ready", rd_ready, 1);

        // Ten dcache-miss cycles, then every bin is read back
        run(1'b1, 1'b0, 1'b0, 5'd3, 10);
        do_snapshot();
        for (int a = 0; a < 32; a++)
            read_bin(5'(a), (a == 3) ? 10 : 0, $sformatf("t1 bin%0d", a));

        // Hold response without yumi, then back-to-back request with yumi
        rd_v = 1'b1;
        rd_addr = 5'd3;
        step();
        rd_v = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t6 hold rd_v_o c%0d", c), rd_v_o, 1);
            check($sformatf("t6 hold data c%0d", c), rd_data, 10);
            check($sformatf("t6 hold ready c%0d", c), rd_ready, 0);
            step();
        end
        rd_yumi = 1'b1;
        rd_v = 1'b1;
        rd_addr = 5'd4;
        #1;
        check("t6 ready with yumi", rd_ready, 1);
        step();
        rd_yumi = 1'b0;
        rd_v = 1'b0;
        check("t6 b2b rd_v_o", rd_v_o, 1);
        check("t6 b2b data", rd_data, 0);
        $display("back-to-back read bin 4 -> %0d", rd_data);
        rd_yumi = 1'b1;
        step();
        rd_yumi = 1'b0;

        // Table-driven single-pattern vectors, each starting from cleared bins
        for (int i = 0; i < 8; i++) begin
            clear_pulse();
            run(vecs[i].vv, vecs[i].ins, vecs[i].frz, vecs[i].rsn, vecs[i].n);
            do_snapshot();
            read_bin(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Alternating instret/reason 30 with 20 frozen cycles
        clear_pulse();
        for (int i = 0; i < 100; i++) begin
            v = 1'b1;
            reason = 5'd30;
            instret = (i % 2 == 0);
            freeze = (i >= 40 && i < 60);
            step();
        end
        v = 1'b0;
        instret = 1'b0;
        freeze = 1'b0;
        do_snapshot();
        read_bin(5'd31, 40, "t2 bin31");
        read_bin(5'd30, 40, "t2 bin30");

        // Busy window, read blocked throughout, second snapshot ignored
        snapshot = 1'b1;
        step();
        snapshot = 1'b0;
        rd_v = 1'b1;
        rd_addr = 5'd31;
        for (int c = 1; c <= 33; c++) begin
            check($sformatf("t3 busy c%0d", c), busy, 1);
            check($sformatf("t3 ready c%0d", c), rd_ready, 0);
            snapshot = (c == 5);
            step();
        end
        snapshot = 1'b0;
        check("t3 busy fell", busy, 0);
        check("t3 ready after", rd_ready, 1);
        step();
        rd_v = 1'b0;
        check("t3 rd_v_o", rd_v_o, 1);
        check("t3 data", rd_data, 40);
        rd_yumi = 1'b1;
        step();
        rd_yumi = 1'b0;

        // Clear and increment in the same cycle; the increment is dropped
        clear_pulse();
        run(1'b1, 1'b0, 1'b0, 5'd7, 5);
        clear = 1'b1;
        v = 1'b1;
        reason = 5'd7;
        step();
        clear = 1'b0;
        step();
        v = 1'b0;
        do_snapshot();
        read_bin(5'd7, 1, "t4 bin7");

        // Clear while bin 10 is being copied: earlier bins keep values, later copy as 0
        clear_pulse();
        run(1'b1, 1'b0, 1'b0, 5'd2, 4);
        run(1'b1, 1'b0, 1'b0, 5'd20, 3);
        snapshot = 1'b1;
        step();
        snapshot = 1'b0;
        repeat (10) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        wait_idle();
        read_bin(5'd2, 4, "copy-clear bin2");
        read_bin(5'd20, 0, "copy-clear bin20");
        clear_pulse();
        read_bin(5'd2, 4, "shadow kept bin2");

        // Increment of the bin being copied in that cycle is included in the copy
        clear_pulse();
        v = 1'b1;
        reason = 5'd25;
        snapshot = 1'b1;
        step();
        snapshot = 1'b0;
        wait_idle();
        v = 1'b0;
        read_bin(5'd25, 27, "copy-inc bin25");

        // 4-bit counter boundary
        s_v = 1'b1;
        repeat (15) step();
        s_v = 1'b0;
        s_snap_read(15, "small 15 incs");
        s_clear = 1'b1;
        step();
        s_clear = 1'b0;
        s_v = 1'b1;
        repeat (17) step();
        s_v = 1'b0;
`ifdef BP_STALL_HIST_SATURATE_EN
        s_exp = 15;
`else
        s_exp = 1;
`endif
        s_snap_read(s_exp, "small 17 incs");

        // Reset during a snapshot aborts it and zeroes live and shadow bins
        clear_pulse();
        run(1'b1, 1'b0, 1'b0, 5'd12, 5);
        do_snapshot();
        snapshot = 1'b1;
        step();
        snapshot = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset busy", busy, 0);
        check("midreset ready", rd_ready, 1);
        check("midreset rd_v_o", rd_v_o, 0);
        read_bin(5'd12, 0, "midreset shadow bin12");
        do_snapshot();
        read_bin(5'd12, 0, "midreset live bin12");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
